iter_shift_unit: RTL and testbench

- Parametrised multi-cycle shift engine for the RV32 datapath; successor to the single-cycle combinational SRA shifter.
- Supports four modes: SLL, SRL, SRA and ROR, with configurable data width and shift step per cycle.
- Uses a start/busy/done handshake so the control unit can stall writeback until the result is ready.
- Result feeds the writeback mux in place of the combinational shifter output.

---
 rtl/iter_shift_unit.sv | 118 +++++++++++
 tb/tb_iter_shift_unit.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/iter_shift_unit.sv
// Multi-cycle SLL/SRL/SRA/ROR engine: shifts a working register by up to STEP bits
// per clock under a start/busy/done handshake.
module iter_shift_unit #(
   parameter int unsigned XLEN = 32,
   parameter int unsigned STEP = 1,
   parameter int unsigned SHW  = $clog2(XLEN)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [1:0]      op,
   input  logic [XLEN-1:0] data_in,
   input  logic [SHW-1:0]  shamt,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_SHIFT = 2'b01,
      ST_DONE  = 2'b10
   } state_e;

   typedef enum logic [1:0] {
      OP_SLL = 2'b00,
      OP_SRL = 2'b01,
      OP_ROR = 2'b10,
      OP_SRA = 2'b11
   } op_e;

   state_e            state_q, state_d;
   op_e               op_q, op_d;
   logic [XLEN-1:0]   result_q, result_d;
   logic [SHW-1:0]    rem_q, rem_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   logic [SHW-1:0]    step_amt;
   logic [SHW-1:0]    inv_amt;
   logic [XLEN-1:0]   shifted;

   // One step of s = min(STEP, rem) bits; s never exceeds rem so rem fits in SHW bits.
   always_comb begin
      step_amt = rem_q;
      if (32'(rem_q) >= STEP) begin
         step_amt = SHW'(STEP);
      end
      // XLEN is a power of two, so the two's complement of s in SHW bits is XLEN - s.
      inv_amt = SHW'(0) - step_amt;
      shifted = result_q;
      case (op_q)
         OP_SLL:  shifted = result_q << step_amt;
         OP_SRL:  shifted = result_q >> step_amt;
         OP_SRA:  shifted = XLEN'($signed(result_q) >>> step_amt);
         OP_ROR:  shifted = (result_q >> step_amt) | (result_q << inv_amt);
         default: shifted = result_q;
      endcase
   end

   // Next-state and datapath control.
   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      result_d = result_q;
      rem_d    = rem_q;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               result_d = data_in;
               rem_d    = shamt;
               op_d     = op_e'(op);
               state_d  = (shamt == SHW'(0)) ? ST_DONE : ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            result_d = shifted;
            rem_d    = rem_q - step_amt;
            if (rem_d == SHW'(0)) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
      done_d = (state_d == ST_DONE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= ST_IDLE;
         op_q     <= OP_SLL;
         result_q <= '0;
         rem_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         result_q <= result_d;
         rem_q    <= rem_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign result = result_q;

endmodule

// File: tb/tb_iter_shift_unit.sv
// Bench for iter_shift_unit: one STEP=1 and one STEP=4 instance checked against a
// plain-arithmetic shift/latency model.
module tb_iter_shift_unit;

   localparam int unsigned XLEN = 32;
   localparam int unsigned SHW  = 5;

   logic            clk = 1'b0;
   logic            reset;
   logic            start1, start4;
   logic [1:0]      op;
   logic [XLEN-1:0] data_in;
   logic [SHW-1:0]  shamt;
   logic            busy1, done1, busy4, done4;
   logic [XLEN-1:0] res1, res4;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   iter_shift_unit #(.XLEN(XLEN), .STEP(1)) u_step1 (
      .clk(clk), .reset(reset), .start(start1), .op(op), .data_in(data_in),
      .shamt(shamt), .busy(busy1), .done(done1), .result(res1)
   );

   iter_shift_unit #(.XLEN(XLEN), .STEP(4)) u_step4 (
      .clk(clk), .reset(reset), .start(start4), .op(op), .data_in(data_in),
      .shamt(shamt), .busy(busy4), .done(done4), .result(res4)
   );

   function automatic logic [31:0] ref_shift(input logic [1:0] o, input logic [31:0] x,
                                             input int sh);
      case (o)
         2'b00:   return x << sh;
         2'b01:   return x >> sh;
         2'b11:   return 32'($signed(x) >>> sh);
         default: return (sh == 0) ? x : ((x >> sh) | (x << (32 - sh)));
      endcase
   endfunction

   function automatic int ref_lat(input int sh, input int step);
      return (sh == 0) ? 1 : ((sh + step - 1) / step) + 1;
   endfunction

   task automatic wait_idle(input bit use4);
      int guard = 0;
      @(negedge clk);
      while ((use4 ? busy4 : busy1) && guard < 200) begin
         @(negedge clk);
         guard++;
      end
   endtask

   // Issues one operation once idle; returns the cycle (after E0) in which done was seen.
   task automatic run_op(input bit use4, input logic [1:0] o, input logic [31:0] x,
                         input logic [4:0] sh, output int lat, output int busy_cnt,
                         output logic [31:0] res);
      wait_idle(use4);
      op = o; data_in = x; shamt = sh;
      if (use4) start4 = 1'b1; else start1 = 1'b1;
      @(posedge clk); #1;
      start1 = 1'b0; start4 = 1'b0;
      lat = -1; busy_cnt = 0;
      for (int c = 1; c <= 200; c++) begin
         if (use4 ? busy4 : busy1) busy_cnt++;
         if (use4 ? done4 : done1) begin
            lat = c;
            break;
         end
         @(posedge clk); #1;
      end
      res = use4 ? res4 : res1;
   endtask

   task automatic test_reset();
      reset = 1'b0; start1 = 1'b0; start4 = 1'b0;
      op = 2'b00; data_in = '0; shamt = '0;
      #12;
      n_cmp++;
      if ({busy1, done1, res1} !== 34'h0) begin
         n_err++;
         $display("FAIL reset_step1: busy=%b done=%b result=%h, need 0/0/0", busy1, done1, res1);
      end
      n_cmp++;
      if ({busy4, done4, res4} !== 34'h0) begin
         n_err++;
         $display("FAIL reset_step4: busy=%b done=%b result=%h, need 0/0/0", busy4, done4, res4);
      end
      @(negedge clk);
      reset = 1'b1;
   endtask

   typedef struct {
      bit          use4;
      logic [1:0]  o;
      logic [31:0] x;
      logic [4:0]  sh;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   task automatic test_directed();
      vec_t v[$];
      int lat, bc;
      logic [31:0] r;
      v.push_back('{1'b0, 2'b11, 32'hFFFFFFF0, 5'd4,  32'hFFFFFFFF, 5});
      v.push_back('{1'b0, 2'b11, 32'h00000010, 5'd2,  32'h00000004, 3});
      v.push_back('{1'b1, 2'b01, 32'h80000000, 5'd31, 32'h00000001, 9});
      v.push_back('{1'b1, 2'b11, 32'h80000000, 5'd31, 32'hFFFFFFFF, 9});
      v.push_back('{1'b0, 2'b00, 32'h00000003, 5'd0,  32'h00000003, 1});
      v.push_back('{1'b1, 2'b00, 32'h00000003, 5'd0,  32'h00000003, 1});
      v.push_back('{1'b0, 2'b00, 32'h00000003, 5'd30, 32'hC0000000, 31});
      v.push_back('{1'b0, 2'b10, 32'h00000001, 5'd1,  32'h80000000, 2});
      v.push_back('{1'b1, 2'b10, 32'h12345678, 5'd8,  32'h78123456, 3});
      foreach (v[i]) begin
         run_op(v[i].use4, v[i].o, v[i].x, v[i].sh, lat, bc, r);
         n_cmp++;
         if (r !== v[i].exp) begin
            n_err++;
            $display("FAIL directed_result[%0d]: got %h, need %h", i, r, v[i].exp);
         end
         n_cmp++;
         if (lat !== v[i].lat) begin
            n_err++;
            $display("FAIL directed_latency[%0d]: done in cycle %0d, need %0d", i, lat, v[i].lat);
         end
         n_cmp++;
         if (bc !== v[i].lat) begin
            n_err++;
            $display("FAIL directed_busy_cycles[%0d]: %0d, need %0d", i, bc, v[i].lat);
         end
      end
   endtask

   task automatic test_start_while_busy();
      int c;
      wait_idle(1'b0);
      op = 2'b11; data_in = 32'hF0000000; shamt = 5'd8; start1 = 1'b1;
      @(posedge clk); #1;
      start1 = 1'b0; c = 1;
      repeat (3) begin @(posedge clk); #1; c++; end
      @(negedge clk);
      op = 2'b00; data_in = 32'h1; shamt = 5'd5; start1 = 1'b1;
      @(posedge clk); #1;
      start1 = 1'b0; c++;
      while (!done1 && c < 200) begin @(posedge clk); #1; c++; end
      n_cmp++;
      if (c !== 9) begin
         n_err++;
         $display("FAIL busy_start_latency: done in cycle %0d, need 9", c);
      end
      n_cmp++;
      if (res1 !== 32'hFFF00000) begin
         n_err++;
         $display("FAIL busy_start_result: got %h, need fff00000", res1);
      end
      @(posedge clk); #1;
      n_cmp++;
      if (busy1 !== 1'b0 || done1 !== 1'b0 || res1 !== 32'hFFF00000) begin
         n_err++;
         $display("FAIL idle_hold: busy=%b done=%b result=%h, need 0/0/fff00000", busy1, done1, res1);
      end
   endtask

   task automatic test_reset_mid_op();
      bit seen_done = 1'b0;
      int lat, bc;
      logic [31:0] r, x;
      wait_idle(1'b0);
      op = 2'b01; data_in = 32'hDEADBEEF; shamt = 5'd20; start1 = 1'b1;
      @(posedge clk); #1;
      start1 = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      n_cmp++;
      if ({busy1, done1, res1} !== 34'h0) begin
         n_err++;
         $display("FAIL async_reset: busy=%b done=%b result=%h, need 0/0/0", busy1, done1, res1);
      end
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk); #1;
         if (done1 || busy1) seen_done = 1'b1;
      end
      n_cmp++;
      if (seen_done !== 1'b0) begin
         n_err++;
         $display("FAIL post_reset_quiet: done/busy seen=%b, need 0", seen_done);
      end
      x = $urandom;
      run_op(1'b0, 2'b01, x, 5'd20, lat, bc, r);
      n_cmp++;
      if (r !== ref_shift(2'b01, x, 20) || lat !== 21) begin
         n_err++;
         $display("FAIL restart_after_reset: result=%h lat=%0d, need %h lat=21",
                  r, lat, ref_shift(2'b01, x, 20));
      end
   endtask

   task automatic test_back_to_back();
      int lat, bc, c;
      logic [31:0] r, x;
      logic [1:0]  o;
      logic [4:0]  sh;
      for (int n = 0; n < 4; n++) begin
         x = $urandom;
         run_op(1'b1, 2'b01, x, 5'($urandom_range(1, 31)), lat, bc, r);
         // Now in the done cycle: raise the next request immediately.
         o = 2'($urandom_range(0, 3)); sh = 5'($urandom_range(1, 31)); x = $urandom;
         op = o; data_in = x; shamt = sh; start4 = 1'b1;
         @(posedge clk); #1;
         n_cmp++;
         if (busy4 !== 1'b0 || res4 !== r) begin
            n_err++;
            $display("FAIL start_in_done_ignored[%0d]: busy=%b result=%h, need 0/%h", n, busy4, res4, r);
         end
         @(posedge clk); #1;
         start4 = 1'b0; c = 1;
         while (!done4 && c < 200) begin @(posedge clk); #1; c++; end
         n_cmp++;
         if (res4 !== ref_shift(o, x, int'(sh)) || c !== ref_lat(int'(sh), 4)) begin
            n_err++;
            $display("FAIL back_to_back[%0d]: result=%h cyc=%0d, need %h cyc=%0d", n, res4, c,
                     ref_shift(o, x, int'(sh)), ref_lat(int'(sh), 4));
         end
      end
   endtask

   task automatic test_random();
      int lat, bc;
      logic [31:0] r, x;
      logic [1:0]  o;
      logic [4:0]  sh;
      bit          u4;
      for (int n = 0; n < 40; n++) begin
         u4 = 1'($urandom_range(0, 1));
         o  = 2'($urandom_range(0, 3));
         sh = 5'($urandom_range(0, 31));
         x  = $urandom;
         run_op(u4, o, x, sh, lat, bc, r);
         n_cmp++;
         if (r !== ref_shift(o, x, int'(sh))) begin
            n_err++;
            $display("FAIL random_result[%0d]: op=%b x=%h sh=%0d step=%0d got %h, need %h", n, o, x,
                     sh, u4 ? 4 : 1, r, ref_shift(o, x, int'(sh)));
         end
         n_cmp++;
         if (lat !== ref_lat(int'(sh), u4 ? 4 : 1)) begin
            n_err++;
            $display("FAIL random_latency[%0d]: sh=%0d step=%0d cycle %0d, need %0d", n, sh,
                     u4 ? 4 : 1, lat, ref_lat(int'(sh), u4 ? 4 : 1));
         end
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_start_while_busy();
      test_reset_mid_op();
      test_back_to_back();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
